// File: rtl/wb_pkg.sv
// Shared widths and types for the register-file write-port arbiter.
// Build option WB_BYPASS_EN (see wb_port_arbiter) does not affect this package.
package wb_pkg;

  localparam int XLEN = 32;
  localparam int AW   = $clog2(XLEN);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PRI,
    SEL_SEC
  } src_sel_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries with a combinational head view.
// Pointers wrap naturally, so DEPTH must be a power of two.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = PW + 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t din_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem[rd_ptr_q];

  // Storage carries no reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and a queued
// long-latency result stream; tracks outstanding destinations. Define
// WB_BYPASS_EN to add forwarding of the registered write to two read ports.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pri_valid,
  input  logic [AW-1:0]   pri_rd,
  input  logic [XLEN-1:0] pri_data,
  input  logic            sec_valid,
  output logic            sec_ready,
  input  logic [AW-1:0]   sec_rd,
  input  logic [XLEN-1:0] sec_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  output logic [31:0]     busy,
  output logic            hold_o,
  output logic            we3,
  output logic [AW-1:0]   wr_addr3,
  output logic [XLEN-1:0] wr_data3
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0]   fwd_addr1,
  input  logic [AW-1:0]   fwd_addr2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2
`endif
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_entry_t       fifo_head;
  src_sel_t        sel;
  logic            we3_q, we3_d;
  logic [AW-1:0]   wr_addr3_q, wr_addr3_d;
  logic [XLEN-1:0] wr_data3_q, wr_data3_d;
  logic [31:0]     busy_q, busy_d;
  logic [SCW-1:0]  starve_q, starve_d;
  logic            hold_q, hold_d;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ('{rd: sec_rd, data: sec_data}),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign sec_ready   = !fifo_full;
  assign fifo_push   = sec_valid && !fifo_full;
  assign fifo_pop    = (sel == SEL_SEC);
  assign issue_ready = !busy_q[issue_rd] || (issue_rd == '0);

  // A primary write to x0 is treated as an idle slot so the queue can drain.
  always_comb begin
    sel = SEL_NONE;
    if (pri_valid && pri_rd != '0) sel = SEL_PRI;
    else if (!fifo_empty)          sel = SEL_SEC;
  end

  always_comb begin
    we3_d      = 1'b0;
    wr_addr3_d = wr_addr3_q;
    wr_data3_d = wr_data3_q;
    case (sel)
      SEL_PRI: begin
        we3_d      = 1'b1;
        wr_addr3_d = pri_rd;
        wr_data3_d = pri_data;
      end
      SEL_SEC: begin
        we3_d      = (fifo_head.rd != '0);
        wr_addr3_d = fifo_head.rd;
        wr_data3_d = fifo_head.data;
      end
      default: ;
    endcase
  end

  // Set is applied after clear so a new issue to the retiring rd stays pending.
  always_comb begin
    busy_d = busy_q;
    if (sel == SEL_SEC)               busy_d[fifo_head.rd] = 1'b0;
    if (issue_valid && issue_ready)   busy_d[issue_rd]     = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = '0;
    if (!fifo_empty && !fifo_pop)
      starve_d = (starve_q == SCW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    hold_d = (starve_d == SCW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3_q      <= 1'b0;
      wr_addr3_q <= '0;
      wr_data3_q <= '0;
      busy_q     <= '0;
      starve_q   <= '0;
      hold_q     <= 1'b0;
    end else begin
      we3_q      <= we3_d;
      wr_addr3_q <= wr_addr3_d;
      wr_data3_q <= wr_data3_d;
      busy_q     <= busy_d;
      starve_q   <= starve_d;
      hold_q     <= hold_d;
    end
  end

  assign we3      = we3_q;
  assign wr_addr3 = wr_addr3_q;
  assign wr_data3 = wr_data3_q;
  assign busy     = busy_q;
  assign hold_o   = hold_q;

`ifdef WB_BYPASS_EN
  assign fwd_hit1  = we3_q && (wr_addr3_q == fwd_addr1) && (fwd_addr1 != '0);
  assign fwd_hit2  = we3_q && (wr_addr3_q == fwd_addr2) && (fwd_addr2 != '0);
  assign fwd_data1 = wr_data3_q;
  assign fwd_data2 = wr_data3_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table plus directed sequences,
// with a write-port scoreboard of expected register-file writes.
module tb_wb_port_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        sv;
    logic [4:0]  srd;
    logic [31:0] sd;
    logic        we1;
    logic [4:0]  a1;
    logic [31:0] d1;
    int          n;
    wr_t         e0;
    wr_t         e1;
  } vec_t;

  localparam int NV = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        pri_valid, sec_valid, issue_valid;
  logic [4:0]  pri_rd, sec_rd, issue_rd;
  logic [31:0] pri_data, sec_data;
  logic        sec_ready, issue_ready, hold_o, we3;
  logic [31:0] busy;
  logic [4:0]  wr_addr3;
  logic [31:0] wr_data3;
`ifdef WB_BYPASS_EN
  logic [4:0]  fwd_addr1, fwd_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   sb_en  = 1'b0;
  wr_t  exp_q[$];
  vec_t vecs[NV];

  wb_port_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .pri_valid   (pri_valid),
    .pri_rd      (pri_rd),
    .pri_data    (pri_data),
    .sec_valid   (sec_valid),
    .sec_ready   (sec_ready),
    .sec_rd      (sec_rd),
    .sec_data    (sec_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .busy        (busy),
    .hold_o      (hold_o),
    .we3         (we3),
    .wr_addr3    (wr_addr3),
    .wr_data3    (wr_data3)
`ifdef WB_BYPASS_EN
    ,
    .fwd_addr1   (fwd_addr1),
    .fwd_addr2   (fwd_addr2),
    .fwd_hit1    (fwd_hit1),
    .fwd_hit2    (fwd_hit2),
    .fwd_data1   (fwd_data1),
    .fwd_data2   (fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One clock: guard the no-primary-write-to-busy rule, then score any write.
  task automatic tick();
    if (pri_valid && pri_rd != 5'd0) begin
      checks++;
      if (busy[pri_rd]) begin
        errors++;
        $display("FAIL pri_to_busy: got busy[%0d]=1, required 0", pri_rd);
      end
    end
    @(posedge clk);
    #1;
    if (sb_en && we3) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_write: got write x%0d=%h, required no write", wr_addr3, wr_data3);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wr_addr3 !== e.rd || wr_data3 !== e.data) begin
          errors++;
          $display("FAIL sb_write: got x%0d=%h, required x%0d=%h", wr_addr3, wr_data3, e.rd, e.data);
        end else begin
          $display("ok   sb_write: x%0d=%h", wr_addr3, wr_data3);
        end
      end
    end
  endtask

  task automatic idle();
    pri_valid   = 1'b0;
    sec_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd3,  32'hAAAA_0001, 1'b1, 5'd5, 32'h55,   1'b1, 5'd3,  32'hAAAA_0001, 2,
                {5'd3, 32'hAAAA_0001}, {5'd5, 32'h55}};
    vecs[1] = '{1'b1, 5'd0,  32'hDEAD_0000, 1'b1, 5'd9, 32'h9,    1'b0, 5'd0,  32'h0, 1,
                {5'd9, 32'h9}, {5'd0, 32'h0}};
    vecs[2] = '{1'b1, 5'd7,  32'h7777,      1'b0, 5'd0, 32'h0,    1'b1, 5'd7,  32'h7777, 1,
                {5'd7, 32'h7777}, {5'd0, 32'h0}};
    vecs[3] = '{1'b1, 5'd0,  32'h1111,      1'b0, 5'd0, 32'h0,    1'b0, 5'd0,  32'h0, 0,
                {5'd0, 32'h0}, {5'd0, 32'h0}};
    vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 32'h1234, 1'b0, 5'd0,  32'h0, 0,
                {5'd0, 32'h0}, {5'd0, 32'h0}};
    vecs[5] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd1, 32'h1,    1'b1, 5'd31, 32'hFFFF_FFFF, 2,
                {5'd31, 32'hFFFF_FFFF}, {5'd1, 32'h1}};

    reset = 1'b1;
    idle();
    pri_rd = '0; pri_data = '0; sec_rd = '0; sec_data = '0; issue_rd = '0;
`ifdef WB_BYPASS_EN
    fwd_addr1 = '0; fwd_addr2 = '0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb_en = 1'b1;

    // Reset state
    issue_rd = 5'd5;
    #1;
    chk("rst_sec_ready", sec_ready, 1);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we3", we3, 0);
    chk("rst_wr_addr3", wr_addr3, 0);
    chk("rst_wr_data3", wr_data3, 0);
    chk("rst_hold", hold_o, 0);

    // Vector table: one stimulus cycle, first-edge check, then drain
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].n > 0) exp_q.push_back(vecs[i].e0);
      if (vecs[i].n > 1) exp_q.push_back(vecs[i].e1);
      pri_valid = vecs[i].pv; pri_rd = vecs[i].prd; pri_data = vecs[i].pd;
      sec_valid = vecs[i].sv; sec_rd = vecs[i].srd; sec_data = vecs[i].sd;
      tick();
      chk($sformatf("vec%0d_we3", i), we3, vecs[i].we1);
      if (vecs[i].we1) begin
        chk($sformatf("vec%0d_addr", i), wr_addr3, vecs[i].a1);
        chk($sformatf("vec%0d_data", i), wr_data3, vecs[i].d1);
      end
      idle();
      repeat (3) tick();
    end

    // x0 entry pops silently while primary targets x0
    pri_valid = 1'b1; pri_rd = 5'd0; pri_data = 32'h0BAD;
    sec_valid = 1'b1; sec_rd = 5'd0; sec_data = 32'h1234;
    tick();
    chk("x0_push_we3", we3, 0);
    exp_q.push_back({5'd9, 32'h9});
    sec_rd = 5'd9; sec_data = 32'h9;
    tick();
    chk("x0_pop_we3", we3, 0);
    sec_valid = 1'b0;
    tick();
    chk("x0_next_we3", we3, 1);
    chk("x0_next_addr", wr_addr3, 9);
    idle();
    tick();

    // Scoreboard set / refuse / clear / same-cycle set+clear
    issue_valid = 1'b1; issue_rd = 5'd12;
    #1 chk("sb_issue_ready", issue_ready, 1);
    tick();
    chk("sb_busy_set", busy, 32'h0000_1000);
    chk("sb_reissue_ready", issue_ready, 0);
    tick();
    issue_valid = 1'b0;
    chk("sb_busy_hold", busy, 32'h0000_1000);
    exp_q.push_back({5'd12, 32'hC0DE});
    sec_valid = 1'b1; sec_rd = 5'd12; sec_data = 32'hC0DE;
    tick();
    sec_valid = 1'b0;
    chk("sb_push_we3", we3, 0);
    chk("sb_push_busy", busy, 32'h0000_1000);
    tick();
    chk("sb_commit_we3", we3, 1);
    chk("sb_commit_busy", busy, 32'h0);
    exp_q.push_back({5'd13, 32'h13});
    sec_valid = 1'b1; sec_rd = 5'd13; sec_data = 32'h13;
    tick();
    sec_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd13;
    #1 chk("sb_setclr_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    chk("sb_setclr_we3", we3, 1);
    chk("sb_setclr_busy", busy, 32'h0000_2000);
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1 chk("sb_x0_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    chk("sb_x0_busy", busy, 32'h0000_2000);

    // Fill under continuous primary traffic, then starvation hold
    pri_valid = 1'b1; pri_rd = 5'd1;
    for (int n = 0; n < 9; n++) begin
      pri_data = 32'h1000_0000 + n;
      exp_q.push_back({5'd1, pri_data});
      sec_valid = 1'b1;
      if (n < 4) begin
        sec_rd = 5'(20 + n); sec_data = 32'h5000 + n;
      end else begin
        sec_rd = 5'd24; sec_data = 32'h0BAD;
      end
      tick();
      chk($sformatf("starve_ready_c%0d", n), sec_ready, (n < 3));
      chk($sformatf("starve_hold_c%0d", n), hold_o, (n >= 8));
    end
    for (int k = 0; k < 4; k++) exp_q.push_back({5'(20 + k), 32'h5000 + k});
    pri_valid = 1'b0;
    tick();
    chk("starve_pop_hold", hold_o, 0);
    chk("starve_pop_we3", we3, 1);
    chk("starve_pop_ready", sec_ready, 1);
    sec_valid = 1'b0;
    repeat (4) tick();

`ifdef WB_BYPASS_EN
    exp_q.push_back({5'd4, 32'hDEAD});
    pri_valid = 1'b1; pri_rd = 5'd4; pri_data = 32'hDEAD;
    tick();
    pri_valid = 1'b0;
    fwd_addr1 = 5'd4; fwd_addr2 = 5'd5;
    #1;
    chk("fwd_hit1", fwd_hit1, 1);
    chk("fwd_data1", fwd_data1, 32'hDEAD);
    chk("fwd_hit2", fwd_hit2, 0);
    fwd_addr1 = 5'd0;
    #1 chk("fwd_hit1_x0", fwd_hit1, 0);
    tick();
`endif

    // Reset mid-run discards queued entries and pending bits
    sb_en = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    pri_valid = 1'b1; pri_rd = 5'd2; pri_data = 32'h2222;
    for (int k = 0; k < 3; k++) begin
      sec_valid = 1'b1; sec_rd = 5'(16 + k); sec_data = 32'h6000 + k;
      tick();
    end
    sec_valid = 1'b0;
    tick();
    chk("pre_rst_busy", busy, 32'h0000_2080);
    #2 reset = 1'b1;
    idle();
    #1;
    chk("rst_async_we3", we3, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_ready", sec_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    sb_en = 1'b1;
    chk("rst_mid_hold", hold_o, 0);
    repeat (5) tick();
    chk("rst_mid_busy", busy, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
